// File: rtl/eth_fcs_strip.sv
// eth_fcs_strip
//   Receives buffered Ethernet frames (destination MAC first, with no
//   preamble or SFD) as a byte stream. It checks the CRC-32 FCS, removes
//   the four FCS bytes and forwards the payload. The last payload byte
//   carries a per-frame error flag. Frames of 4 bytes or fewer (runts)
//   are dropped and counted.
//
// Ports
//   Clk, Rst_n                 clock, asynchronous active-low reset
//   Input_data/valid/last      byte stream from gmii_buffer
//   Input_ready                a beat is accepted when Input_valid && Input_ready
//   Output_data/valid/last     payload stream; single registered output stage
//   Output_error               FCS mismatch, meaningful only with Output_last
//   Output_ready               downstream accepts the beat
//   Status_frame_count         frames forwarded, good or bad
//   Status_fcs_error_count     forwarded frames with Output_error=1
//   Status_runt_count          dropped frames of 4 or fewer bytes
module eth_fcs_strip #(
  parameter int COUNTER_WIDTH = 32
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic [7:0]               Input_data,
  input  logic                     Input_valid,
  input  logic                     Input_last,
  output logic                     Input_ready,
  output logic [7:0]               Output_data,
  output logic                     Output_valid,
  output logic                     Output_last,
  output logic                     Output_error,
  input  logic                     Output_ready,
  output logic [COUNTER_WIDTH-1:0] Status_frame_count,
  output logic [COUNTER_WIDTH-1:0] Status_fcs_error_count,
  output logic [COUNTER_WIDTH-1:0] Status_runt_count
);

  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};

  // Reflected CRC-32, one byte at a time, least significant bit first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h00_0000, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ({1'b0, c[31:1]} ^ CRC_POLY) : {1'b0, c[31:1]};
    end
    return c;
  endfunction

  logic [31:0]              sr_r;          // delay line; [31:24] holds the oldest byte
  logic [2:0]               fill_r;        // bytes held in sr_r, 0..4
  logic [31:0]              crc_r;
  logic [7:0]               out_data_r;
  logic                     out_valid_r;
  logic                     out_last_r;
  logic                     out_error_r;
  logic [COUNTER_WIDTH-1:0] frame_cnt_r;
  logic [COUNTER_WIDTH-1:0] fcs_err_cnt_r;
  logic [COUNTER_WIDTH-1:0] runt_cnt_r;

  logic        in_ready_s;
  logic        accept_s;
  logic        full_s;
  logic        out_xfer_s;
  logic [31:0] crc_next_s;
  logic        good_s;

  // Handshake qualifiers and CRC lookahead including the byte being accepted.
  always_comb begin
    in_ready_s = 1'b0;
    if (Rst_n) begin
      in_ready_s = !out_valid_r || Output_ready;
    end else begin
      in_ready_s = 1'b0;
    end
    accept_s   = Input_valid && in_ready_s;
    full_s     = (fill_r == 3'd4);
    out_xfer_s = out_valid_r && Output_ready;
    crc_next_s = crc32_byte(crc_r, Input_data);
    good_s     = (crc_next_s == CRC_RESIDUE);
  end

  // Delay line, CRC accumulator and output register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sr_r        <= 32'h0000_0000;
      fill_r      <= 3'd0;
      crc_r       <= CRC_INIT;
      out_data_r  <= 8'h00;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_error_r <= 1'b0;
    end else begin
      // The output register is loaded only when the delay line is full, so
      // the four most recent bytes (the FCS at frame end) are never emitted.
      if (accept_s && full_s) begin
        out_data_r  <= sr_r[31:24];
        out_valid_r <= 1'b1;
        out_last_r  <= Input_last;
        out_error_r <= Input_last && !good_s;
      end else if (out_xfer_s) begin
        out_valid_r <= 1'b0;
      end

      if (accept_s) begin
        if (Input_last) begin
          // Return to start-of-frame so the next byte can follow immediately.
          sr_r   <= 32'h0000_0000;
          fill_r <= 3'd0;
          crc_r  <= CRC_INIT;
        end else begin
          sr_r   <= {sr_r[23:0], Input_data};
          fill_r <= full_s ? fill_r : (fill_r + 3'd1);
          crc_r  <= crc_next_s;
        end
      end
    end
  end

  // Status counters, updated on the beat that ends a frame.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      frame_cnt_r   <= '0;
      fcs_err_cnt_r <= '0;
      runt_cnt_r    <= '0;
    end else if (accept_s && Input_last) begin
      if (full_s) begin
        frame_cnt_r <= frame_cnt_r + CNT_ONE;
        if (!good_s) begin
          fcs_err_cnt_r <= fcs_err_cnt_r + CNT_ONE;
        end
      end else begin
        runt_cnt_r <= runt_cnt_r + CNT_ONE;
      end
    end
  end

  assign Input_ready            = in_ready_s;
  assign Output_data            = out_data_r;
  assign Output_valid           = out_valid_r;
  assign Output_last            = out_last_r;
  assign Output_error           = out_error_r;
  assign Status_frame_count     = frame_cnt_r;
  assign Status_fcs_error_count = fcs_err_cnt_r;
  assign Status_runt_count      = runt_cnt_r;

endmodule

// File: tb/tb_eth_fcs_strip.sv
// Directed testbench for eth_fcs_strip: a byte-stream driver, a scoreboard
// of expected payload beats, and a negedge monitor that also checks
// stall stability and Input_ready under backpressure.
module tb_eth_fcs_strip;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [7:0] d;
    logic       last;
    logic       err;
  } exp_t;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic [7:0]  Input_data;
  logic        Input_valid;
  logic        Input_last;
  logic        Input_ready;
  logic [7:0]  Output_data;
  logic        Output_valid;
  logic        Output_last;
  logic        Output_error;
  logic        Output_ready;
  logic [31:0] Status_frame_count;
  logic [31:0] Status_fcs_error_count;
  logic [31:0] Status_runt_count;

  int          err_cnt = 0;
  int          chk_cnt = 0;
  int unsigned ready_pct = 100;
  logic        mon_en = 1'b1;
  exp_t        exp_q[$];
  exp_t        mon_e;
  logic        stall_r = 1'b0;
  logic [7:0]  hold_d;
  logic        hold_last;
  logic        hold_err;

  eth_fcs_strip #(.COUNTER_WIDTH(32)) dut (
    .Clk                    (Clk),
    .Rst_n                  (Rst_n),
    .Input_data             (Input_data),
    .Input_valid            (Input_valid),
    .Input_last             (Input_last),
    .Input_ready            (Input_ready),
    .Output_data            (Output_data),
    .Output_valid           (Output_valid),
    .Output_last            (Output_last),
    .Output_error           (Output_error),
    .Output_ready           (Output_ready),
    .Status_frame_count     (Status_frame_count),
    .Status_fcs_error_count (Status_fcs_error_count),
    .Status_runt_count      (Status_runt_count)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference CRC-32 (IEEE 802.3) of a byte sequence, final value inverted.
  function automatic logic [31:0] crc32(input bq_t b);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (b[i]) begin
      c = c ^ {24'h0, b[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic bq_t with_fcs(input bq_t p);
    bq_t         f;
    logic [31:0] c;
    f = p;
    c = crc32(p);
    f.push_back(c[7:0]);
    f.push_back(c[15:8]);
    f.push_back(c[23:16]);
    f.push_back(c[31:24]);
    return f;
  endfunction

  task automatic expect_frame(input bq_t f, input logic bad);
    exp_t e;
    for (int i = 0; i < f.size() - 4; i++) begin
      e.d    = f[i];
      e.last = (i == f.size() - 5);
      e.err  = bad;
      exp_q.push_back(e);
    end
  endtask

  // Drives one frame starting at posedge+1; returns at posedge+1 after the final beat.
  task automatic send_frame(input bq_t f, input int unsigned gap_pct, input logic end_frame);
    int   w;
    logic acc;
    for (int i = 0; i < f.size(); i++) begin
      while ($urandom_range(99) < gap_pct) begin
        Input_valid = 1'b0;
        @(posedge Clk); #1;
      end
      Input_valid = 1'b1;
      Input_data  = f[i];
      Input_last  = end_frame && (i == f.size() - 1);
      w   = 0;
      acc = 1'b0;
      while (!acc && w < 2000) begin
        @(negedge Clk);
        acc = Input_ready;
        @(posedge Clk); #1;
        w++;
      end
      if (!acc) check("in_timeout", 32'd0, 32'd1);
    end
    Input_valid = 1'b0;
    Input_last  = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((exp_q.size() != 0 || Output_valid) && w < 20000) begin
      @(posedge Clk); #1;
      w++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_counts(input string tag, input int fr, input int fe, input int rn);
    check({tag, "_frames"}, Status_frame_count, 32'(fr));
    check({tag, "_fcserr"}, Status_fcs_error_count, 32'(fe));
    check({tag, "_runts"}, Status_runt_count, 32'(rn));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ovalid"}, 32'(Output_valid), 32'd0);
    check({tag, "_odata"}, 32'(Output_data), 32'd0);
    check({tag, "_olast"}, 32'(Output_last), 32'd0);
    check({tag, "_oerr"}, 32'(Output_error), 32'd0);
    check({tag, "_iready"}, 32'(Input_ready), 32'd0);
    check_counts(tag, 0, 0, 0);
  endtask

  // Random downstream backpressure, changed just after each rising edge.
  always begin
    @(posedge Clk); #1;
    Output_ready = ($urandom_range(99) < ready_pct);
  end

  // Output monitor: scoreboard compare, stall stability, Input_ready under stall.
  always @(negedge Clk) begin
    if (Rst_n && mon_en) begin
      if (stall_r) begin
        check("stall_valid", 32'(Output_valid), 32'd1);
        check("stall_data", 32'(Output_data), 32'(hold_d));
        check("stall_last", 32'(Output_last), 32'(hold_last));
        check("stall_err", 32'(Output_error), 32'(hold_err));
      end
      if (Output_valid && !Output_ready) check("iready_stall", 32'(Input_ready), 32'd0);
      stall_r   = Output_valid && !Output_ready;
      hold_d    = Output_data;
      hold_last = Output_last;
      hold_err  = Output_error;
      if (Output_valid && Output_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_out", 32'(Output_data), 32'hFFFF_FFFF);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_data", 32'(Output_data), 32'(mon_e.d));
          check("out_last", 32'(Output_last), 32'(mon_e.last));
          if (mon_e.last) check("out_err", 32'(Output_error), 32'(mon_e.err));
        end
      end
    end
  end

  initial begin
    bq_t  nom, bad, runt, mini, p, f;
    exp_t e;
    int   n;
    nom  = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
             8'h26, 8'h39, 8'hF4, 8'hCB};
    runt = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};

    Rst_n        = 1'b0;
    Input_valid  = 1'b0;
    Input_last   = 1'b0;
    Input_data   = 8'h00;
    Output_ready = 1'b1;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check_reset_state("reset");
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    @(posedge Clk); #1;

    // Nominal "123456789" frame with its known FCS.
    ready_pct = 100;
    expect_frame(nom, 1'b0);
    send_frame(nom, 0, 1'b1);
    drain();
    check_counts("nominal", 1, 0, 0);

    // First byte corrupted, FCS unchanged.
    bad    = nom;
    bad[0] = 8'h30;
    expect_frame(bad, 1'b1);
    send_frame(bad, 0, 1'b1);
    drain();
    check_counts("badfcs", 2, 1, 0);

    // Four-byte runt: dropped, nothing emitted.
    send_frame(runt, 0, 1'b1);
    drain();
    check_counts("runt", 2, 1, 1);

    // Minimum five-byte frame: exactly one payload byte 0xAA.
    p    = '{8'hAA};
    mini = with_fcs(p);
    e.d = 8'hAA; e.last = 1'b1; e.err = 1'b0;
    exp_q.push_back(e);
    send_frame(mini, 0, 1'b1);
    drain();
    check_counts("minimum", 3, 1, 1);

    // Back-to-back frames: second starts the cycle after the first ends.
    expect_frame(bad, 1'b1);
    expect_frame(nom, 1'b0);
    send_frame(bad, 0, 1'b1);
    send_frame(nom, 0, 1'b1);
    drain();
    check_counts("b2b", 5, 2, 1);

    // Random frames under heavy backpressure with input gaps.
    ready_pct = 10;
    for (int fr = 0; fr < 20; fr++) begin
      p.delete();
      n = $urandom_range(1, 40);
      for (int i = 0; i < n; i++) p.push_back(8'($urandom_range(255)));
      f = with_fcs(p);
      expect_frame(f, 1'b0);
      send_frame(f, 30, 1'b1);
    end
    drain();
    check_counts("random", 25, 2, 1);

    // Reset in the middle of a frame, then a nominal frame.
    ready_pct = 100;
    mon_en    = 1'b0;
    p = nom[0:6];
    send_frame(p, 0, 1'b0);
    Rst_n = 1'b0;
    @(negedge Clk);
    check_reset_state("midreset");
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    exp_q.delete();
    stall_r = 1'b0;
    mon_en  = 1'b1;
    expect_frame(nom, 1'b0);
    send_frame(nom, 0, 1'b1);
    drain();
    check_counts("post_reset", 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
